sd_photo_slideshow_ctrl: RTL
============================

// Module: sd_photo_slideshow_ctrl
// PURPOSE
//  Sequencer between SD-card controller read port and SDRAM write FIFO. Streams PHOTO_NUM
//  raw RGB565 images, held as contiguous sector runs on SD, into the SDRAM frame buffer one
//  at a time. Holds each photo on display for HOLD_CYCLES, then reloads the SDRAM write
//  pointer and fetches the next photo (wraps). Runs in the 50 MHz SD user clock domain.
// PARAMETERS
//  SEC_PER_PHOTO  1200          sectors per image (640*480*2B/512B)
//  PHOTO_NUM      4             number of images, >=1
//  BASE_SEC       32'd16640     first sector of image 0
//  PHOTO_STRIDE   32'd1200      sector distance between consecutive images
//  HOLD_CYCLES    150_000_000   display time per image in clk cycles (3 s @ 50 MHz)
// PORTS
//  clk          in   1   50 MHz SD user clock
//  rst          in   1   synchronous reset, active high
//  init_done    in   1   SD and SDRAM init complete; low forces IDLE
//  rd_busy      in   1   SD controller read busy
//  next_photo   in   1   one-cycle advance request (used only with SLIDESHOW_KEY_EN)
//  rd_start_en  out  1   one-cycle sector read start pulse
//  rd_sec_addr  out  32  sector address, valid and stable while rd_start_en high
//  wr_load      out  1   one-cycle pulse: reset SDRAM write address, clear write FIFO
//  photo_idx    out  8   index of image being loaded/shown
//  photo_done   out  1   one-cycle pulse when the last sector of an image completes
// BEHAVIOUR
//  Reset: rd_start_en=0, rd_sec_addr=0, wr_load=0, photo_idx=0, photo_done=0, state IDLE,
//   sec_cnt=0, hold_cnt=0, photo_base=BASE_SEC. All outputs registered.
//  FSM:
//   IDLE   : wait init_done=1 -> LOAD.
//   LOAD   : wr_load=1 for exactly one cycle; sec_cnt=0 -> ISSUE.
//   ISSUE  : rd_start_en=1 for one cycle, rd_sec_addr=photo_base+sec_cnt -> WAIT_H.
//   WAIT_H : wait rd_busy rising (sampled 0->1) -> WAIT_L.
//   WAIT_L : wait rd_busy falling (1->0). If sec_cnt==SEC_PER_PHOTO-1: photo_done pulse,
//            hold_cnt=0 -> HOLD; else sec_cnt+1 -> ISSUE.
//   HOLD   : hold_cnt increments each cycle; at hold_cnt==HOLD_CYCLES-1 advance: photo_idx
//            = (idx==PHOTO_NUM-1)?0:idx+1, photo_base += PHOTO_STRIDE or reload BASE_SEC on
//            wrap -> LOAD.
//  Timing: rd_start_en to next rd_start_en >= 3 cycles plus SD busy time; LOAD->first
//   rd_start_en = 1 cycle.
//  Address arithmetic: 32-bit unsigned, incremental (no multiplier), overflow wraps mod 2^32.
//  Boundaries:
//   - init_done falls in any state: next cycle IDLE, in-flight read abandoned, photo_idx
//     and photo_base kept; re-entry via LOAD restarts current image from sector 0.
//   - rd_busy already high on entry to WAIT_H: wait for it to fall then rise; never
//     re-pulse rd_start_en.
//   - PHOTO_NUM==1: HOLD never advances (stays in HOLD; image not re-fetched).
//   - rst has priority over all other inputs in the same cycle.
// CONFIGURATION
//  SLIDESHOW_KEY_EN defined: next_photo=1 in HOLD advances immediately (same action as
//   timer expiry); next_photo and timer expiry in same cycle advance once; next_photo in
//   any other state is ignored (not queued).
//  Not defined: next_photo ignored; advance only on HOLD_CYCLES expiry.
// TESTING (bench: SEC_PER_PHOTO=3, PHOTO_NUM=2, BASE_SEC=100, PHOTO_STRIDE=10,
//  HOLD_CYCLES=20; SD model raises rd_busy 2 cycles after rd_start_en, holds 8 cycles)
//  1 rst release, init_done=1 -> wr_load pulse once, then rd_sec_addr 100,101,102, each
//    with single-cycle rd_start_en; photo_done pulse after 3rd busy fall; photo_idx=0.
//  2 Continue -> after exactly 20 HOLD cycles wr_load pulse, addrs 110,111,112, photo_idx=1;
//    next hold wraps to photo_idx=0, addrs 100..102 again.
//  3 Drop init_done during 2nd sector busy -> IDLE next cycle, no further rd_start_en;
//    restore -> wr_load, restart at addr 100.
//  4 Model asserts rd_busy continuously 5 cycles before rd_start_en -> no duplicate
//    rd_start_en; sequence proceeds after fall/rise.
//  5 SLIDESHOW_KEY_EN: next_photo at HOLD cycle 5 -> wr_load next cycle, photo_idx=1;
//    next_photo during ISSUE/WAIT -> no effect. Without macro, same stimulus -> 20-cycle hold.
//  6 PHOTO_NUM=1 -> one fetch of addrs 100..102, then no further wr_load/rd_start_en.

Source files
------------

// File: rtl/sd_photo_slideshow_ctrl.sv
// sd_photo_slideshow_ctrl: streams PHOTO_NUM SD sector runs into the SDRAM frame buffer, holding each image on screen.
// Define SLIDESHOW_KEY_EN to let a next_photo pulse cut the hold short.
module sd_photo_slideshow_ctrl #(
    parameter int unsigned SEC_PER_PHOTO = 1200,
    parameter int unsigned PHOTO_NUM     = 4,
    parameter logic [31:0] BASE_SEC      = 32'd16640,
    parameter logic [31:0] PHOTO_STRIDE  = 32'd1200,
    parameter int unsigned HOLD_CYCLES   = 150_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        rd_busy,
    input  logic        next_photo,
    output logic        rd_start_en,
    output logic [31:0] rd_sec_addr,
    output logic        wr_load,
    output logic [7:0]  photo_idx,
    output logic        photo_done
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_H, WAIT_L, HOLD} state_t;
    state_t state_q, state_d;
    logic [31:0] sec_cnt_q, sec_cnt_d, hold_cnt_q, hold_cnt_d;
    logic [31:0] photo_base_q, photo_base_d, rd_sec_addr_q, rd_sec_addr_d;
    logic [7:0]  photo_idx_q, photo_idx_d;
    logic        busy_prev_q, rd_start_en_q, rd_start_en_d, wr_load_q, wr_load_d;
    logic        photo_done_q, photo_done_d, key, advance, last_photo;

`ifdef SLIDESHOW_KEY_EN
    assign key = next_photo;
`else
    logic key_unused;
    assign key_unused = next_photo;
    assign key = 1'b0;
`endif

    assign last_photo = photo_idx_q == 8'(PHOTO_NUM - 1);
    // A single image never needs re-fetching, so HOLD becomes terminal
    assign advance = (PHOTO_NUM > 1) && (hold_cnt_q == HOLD_CYCLES - 1 || key);

    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        photo_base_d = photo_base_q;
        photo_idx_d  = photo_idx_q;
        photo_done_d = 1'b0;
        case (state_q)
            IDLE:   state_d = LOAD;
            LOAD: begin
                sec_cnt_d = '0;
                state_d   = ISSUE;
            end
            ISSUE:  state_d = WAIT_H;
            // Edge-qualified so a busy level left over from before the request is not mistaken for the ack
            WAIT_H: state_d = (rd_busy && !busy_prev_q) ? WAIT_L : WAIT_H;
            WAIT_L: begin
                if (!rd_busy && sec_cnt_q == SEC_PER_PHOTO - 1) begin
                    photo_done_d = 1'b1;
                    hold_cnt_d   = '0;
                    state_d      = HOLD;
                end else if (!rd_busy) begin
                    sec_cnt_d = sec_cnt_q + 1;
                    state_d   = ISSUE;
                end
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q + 1;
                if (advance) begin
                    photo_idx_d  = last_photo ? 8'd0 : photo_idx_q + 8'd1;
                    photo_base_d = last_photo ? BASE_SEC : photo_base_q + PHOTO_STRIDE;
                    state_d      = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!init_done) begin
            state_d      = IDLE;
            photo_done_d = 1'b0;
            photo_idx_d  = photo_idx_q;
            photo_base_d = photo_base_q;
        end
        wr_load_d     = state_d == LOAD;
        rd_start_en_d = state_d == ISSUE;
        rd_sec_addr_d = rd_start_en_d ? photo_base_q + sec_cnt_d : rd_sec_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sec_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            photo_base_q  <= BASE_SEC;
            photo_idx_q   <= '0;
            rd_sec_addr_q <= '0;
            rd_start_en_q <= 1'b0;
            wr_load_q     <= 1'b0;
            photo_done_q  <= 1'b0;
            busy_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sec_cnt_q     <= sec_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            photo_base_q  <= photo_base_d;
            photo_idx_q   <= photo_idx_d;
            rd_sec_addr_q <= rd_sec_addr_d;
            rd_start_en_q <= rd_start_en_d;
            wr_load_q     <= wr_load_d;
            photo_done_q  <= photo_done_d;
            busy_prev_q   <= rd_busy;
        end
    end

    assign rd_start_en = rd_start_en_q;
    assign rd_sec_addr = rd_sec_addr_q;
    assign wr_load     = wr_load_q;
    assign photo_idx   = photo_idx_q;
    assign photo_done  = photo_done_q;
endmodule
